// File: rtl/uart_rx_if.sv
// Serial receive bus: line input, frame configuration and received-word/status outputs.
interface uart_rx_if #(
    parameter int unsigned DATA_LENGTH = 8
);
    logic                   RX_IN;
    logic [5:0]             PRESCALE;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [DATA_LENGTH-1:0] P_DATA;
    logic                   DATA_VALID;
    logic                   PAR_ERR;
    logic                   STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled, 3-sample majority vote per bit, optional parity,
// LSB-first deserialisation with one-cycle valid/error pulses at frame end.
module uart_rx #(
    parameter int unsigned DATA_LENGTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.slave  bus
);
    localparam int unsigned CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [5:0]             edge_cnt;
    logic [5:0]             prescale_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   par_err_q;
    logic [DATA_LENGTH-1:0] shreg;
    logic [2:0]             samp;

    logic [5:0] half;
    logic [5:0] last_tick;
    logic       last;
    logic       vote;

    assign half      = prescale_q >> 1;
    assign last_tick = prescale_q - 6'd1;
    assign last      = (edge_cnt == last_tick);
    assign vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            edge_cnt       <= '0;
            prescale_q     <= '0;
            bit_cnt        <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_err_q      <= 1'b0;
            shreg          <= '0;
            samp           <= '0;
            bus.P_DATA     <= '0;
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;
        end else begin
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;

            // Per-bit tick counter and the three mid-bit samples
            if (state != IDLE) begin
                edge_cnt <= last ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) samp[0] <= bus.RX_IN;
                if (edge_cnt == half)        samp[1] <= bus.RX_IN;
                if (edge_cnt == half + 6'd1) samp[2] <= bus.RX_IN;
            end

            case (state)
                IDLE: begin
                    if (!bus.RX_IN) begin
                        // The detect cycle is tick 0, so the next cycle is tick 1
                        state      <= START;
                        edge_cnt   <= 6'd1;
                        prescale_q <= bus.PRESCALE;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        par_err_q  <= 1'b0;
                    end
                end
                START: begin
                    if ((edge_cnt == half + 6'd2) && vote) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (last) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (last) begin
                        shreg <= {vote, shreg[DATA_LENGTH-1:1]};
                        if (bit_cnt == CNT_W'(DATA_LENGTH - 1)) begin
                            state <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (last) begin
                        par_err_q <= ((^shreg) ^ par_typ_q) != vote;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (last) begin
                        state <= IDLE;
                        if (!vote)     bus.STP_ERR <= 1'b1;
                        if (par_err_q) bus.PAR_ERR <= 1'b1;
                        if (vote && !par_err_q) begin
                            bus.DATA_VALID <= 1'b1;
                            bus.P_DATA     <= shreg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, parity/stop errors, glitch reject,
// back-to-back frames and reset mid-frame.
module tb_uart_rx;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_rx_if #(.DATA_LENGTH(8)) bus ();

    uart_rx #(.DATA_LENGTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Event recorder: counts each output pulse and remembers when it happened
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int         dv_cyc = 0, dv_prev_cyc = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] dv_data = '0, dv_prev_data = '0;
    always @(negedge CLK) begin
        if (bus.DATA_VALID) begin
            dv_prev_cyc  <= dv_cyc;
            dv_prev_data <= dv_data;
            dv_cyc       <= cyc;
            dv_data      <= bus.P_DATA;
            dv_cnt       <= dv_cnt + 1;
        end
        if (bus.PAR_ERR) begin
            pe_cyc <= cyc;
            pe_cnt <= pe_cnt + 1;
        end
        if (bus.STP_ERR) begin
            se_cyc <= cyc;
            se_cnt <= se_cnt + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int p, input logic pe,
                              input logic pbit, input logic sbit, output int t0);
        bus.PRESCALE = 6'(p);
        bus.PAR_EN   = pe;
        t0 = cyc;
        bus.RX_IN = 1'b0;
        step(p);
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = data[i];
            step(p);
        end
        if (pe) begin
            bus.RX_IN = pbit;
            step(p);
        end
        bus.RX_IN = sbit;
        step(p);
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(3);
        tests++;
        if (bus.DATA_VALID !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b expected 0", bus.DATA_VALID); end
        tests++;
        if (bus.PAR_ERR !== 1'b0) begin fails++; $display("FAIL reset_pe: got %b expected 0", bus.PAR_ERR); end
        tests++;
        if (bus.STP_ERR !== 1'b0) begin fails++; $display("FAIL reset_se: got %b expected 0", bus.STP_ERR); end
        tests++;
        if (bus.P_DATA !== 8'h00) begin fails++; $display("FAIL reset_pdata: got %h expected 00", bus.P_DATA); end
        RST = 1'b0;
        step(2);
    endtask

    task automatic test_no_parity();
        int t0, dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, t0);
        step(4);
        tests++;
        if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL np_dv_count: got %0d expected 1", dv_cnt - dv0); end
        tests++;
        if (dv_cyc - t0 !== 80) begin fails++; $display("FAIL np_latency: got %0d expected 80", dv_cyc - t0); end
        tests++;
        if (dv_data !== 8'hA5) begin fails++; $display("FAIL np_data: got %h expected a5", dv_data); end
        tests++;
        if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            fails++; $display("FAIL np_errors: got %0d expected 0", (pe_cnt - pe0) + (se_cnt - se0));
        end
    endtask

    task automatic test_parity();
        int t0, dv0, pe0, se0;
        bus.PAR_TYP = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, t0);
        step(4);
        tests++;
        if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL par_ok_dv: got %0d expected 1", dv_cnt - dv0); end
        tests++;
        if (dv_cyc - t0 !== 176) begin fails++; $display("FAIL par_ok_latency: got %0d expected 176", dv_cyc - t0); end
        tests++;
        if (bus.P_DATA !== 8'h3C) begin fails++; $display("FAIL par_ok_data: got %h expected 3c", bus.P_DATA); end
        dv0 = dv_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, t0);
        step(4);
        tests++;
        if (pe_cnt - pe0 !== 1) begin fails++; $display("FAIL par_err_count: got %0d expected 1", pe_cnt - pe0); end
        tests++;
        if (pe_cyc - t0 !== 176) begin fails++; $display("FAIL par_err_latency: got %0d expected 176", pe_cyc - t0); end
        tests++;
        if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL par_err_dv: got %0d expected 0", dv_cnt - dv0); end
        tests++;
        if (bus.P_DATA !== 8'h3C) begin fails++; $display("FAIL par_err_hold: got %h expected 3c", bus.P_DATA); end
        tests++;
        if (se_cnt - se0 !== 0) begin fails++; $display("FAIL par_err_stop: got %0d expected 0", se_cnt - se0); end
    endtask

    task automatic test_stop_error();
        int t0, dv0, se0;
        dv0 = dv_cnt; se0 = se_cnt;
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, t0);
        step(4);
        tests++;
        if (se_cnt - se0 !== 1) begin fails++; $display("FAIL stp_count: got %0d expected 1", se_cnt - se0); end
        tests++;
        if (se_cyc - t0 !== 80) begin fails++; $display("FAIL stp_latency: got %0d expected 80", se_cyc - t0); end
        tests++;
        if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL stp_dv: got %0d expected 0", dv_cnt - dv0); end
        step(20);
        dv0 = dv_cnt;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, t0);
        step(4);
        tests++;
        if (dv_cnt - dv0 !== 1 || dv_data !== 8'h5A) begin
            fails++; $display("FAIL stp_recover: got count %0d data %h expected 1 5a", dv_cnt - dv0, dv_data);
        end
    endtask

    task automatic test_glitch();
        int t0, dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        bus.PRESCALE = 6'd16;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        step(3);
        bus.RX_IN = 1'b1;
        step(200);
        tests++;
        if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            fails++; $display("FAIL glitch_quiet: got %0d pulses expected 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, t0);
        step(4);
        tests++;
        if (dv_cnt - dv0 !== 1 || dv_data !== 8'h81) begin
            fails++; $display("FAIL glitch_next: got count %0d data %h expected 1 81", dv_cnt - dv0, dv_data);
        end
        tests++;
        if (dv_cyc - t0 !== 160) begin fails++; $display("FAIL glitch_latency: got %0d expected 160", dv_cyc - t0); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, dv0, pe0;
        bus.PAR_TYP = 1'b1;
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'h55, 32, 1'b1, 1'b1, 1'b1, t0);
        send_frame(8'hAA, 32, 1'b1, 1'b1, 1'b1, t1);
        step(4);
        tests++;
        if (dv_cnt - dv0 !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", dv_cnt - dv0); end
        tests++;
        if (dv_cyc - dv_prev_cyc !== 352) begin fails++; $display("FAIL b2b_spacing: got %0d expected 352", dv_cyc - dv_prev_cyc); end
        tests++;
        if (dv_prev_data !== 8'h55) begin fails++; $display("FAIL b2b_first: got %h expected 55", dv_prev_data); end
        tests++;
        if (dv_data !== 8'hAA) begin fails++; $display("FAIL b2b_second: got %h expected aa", dv_data); end
        tests++;
        if (dv_cyc - t1 !== 352 || pe_cnt - pe0 !== 0) begin
            fails++; $display("FAIL b2b_latency: got %0d perr %0d expected 352 0", dv_cyc - t1, pe_cnt - pe0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0, dv0, pe0, se0;
        logic [7:0] d;
        d = 8'hC3;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        step(8);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = d[i];
            step(8);
        end
        bus.RX_IN = d[4];
        step(3);
        RST = 1'b1;
        step(2);
        tests++;
        if (bus.P_DATA !== 8'h00 || bus.DATA_VALID !== 1'b0 || bus.PAR_ERR !== 1'b0 || bus.STP_ERR !== 1'b0) begin
            fails++; $display("FAIL rst_mid_outputs: got %h %b%b%b expected 00 000",
                              bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
        end
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        step(120);
        tests++;
        if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            fails++; $display("FAIL rst_mid_quiet: got %0d pulses expected 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, t0);
        step(4);
        tests++;
        if (dv_cnt - dv0 !== 1 || dv_data !== 8'hC3) begin
            fails++; $display("FAIL rst_mid_next: got count %0d data %h expected 1 c3", dv_cnt - dv0, dv_data);
        end
    endtask

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        test_reset();
        test_no_parity();
        test_parity();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
